// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queued command player / response checker for the RemoteComm path.
// Commands are pushed into a DEPTH-entry FIFO together with the number of
// responses they expect and a per-response timeout. On start the queue is
// played in order: each head entry is sent, cmd_sent is awaited, then every
// response byte is checked (ACK for intermediate bytes, POS_ACK for the last).
// An entry is popped only once its final POS_ACK arrives.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   load_cmd/load_data/load_nresp/load_tmo   FIFO push
//   start, abort                     playback control
//   send_cmd, cmd, cmd_sent          transmit handshake
//   resp_rdy, resp                   response input
//   full, count, ovf                 FIFO status (ovf sticky)
//   busy, done                       playback status (done is a 1-cycle pulse)
//   err, err_code, err_idx, bad_resp sticky first-error report
module cmd_sequencer #(
  parameter int                DEPTH    = 8,
  parameter int                CMD_W    = 16,
  parameter int                RESP_W   = 8,
  parameter int                TMO_W    = 24,
  parameter int                SENT_TMO = 60000,
  parameter logic [RESP_W-1:0] POS_ACK  = 8'hA5,
  parameter logic [RESP_W-1:0] ACK      = 8'h5A
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_cmd,
  input  logic [CMD_W-1:0]           load_data,
  input  logic [3:0]                 load_nresp,
  input  logic [TMO_W-1:0]           load_tmo,
  input  logic                       start,
  input  logic                       abort,
  output logic                       send_cmd,
  output logic [CMD_W-1:0]           cmd,
  input  logic                       cmd_sent,
  input  logic                       resp_rdy,
  input  logic [RESP_W-1:0]          resp,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 err_code,
  output logic [7:0]                 err_idx,
  output logic [RESP_W-1:0]          bad_resp
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  // The timer reads 0 in the first waiting cycle, so a limit of L expires
  // on the edge where the timer would step from L-1 to L.
  localparam logic [TMO_W-1:0] SENT_LIM = TMO_W'(SENT_TMO - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_SENT = 2'd2, WAIT_RESP = 2'd3} state_t;

  state_t              state_r, state_nx;
  logic [CMD_W-1:0]    mem_data_r  [DEPTH];
  logic [3:0]          mem_nresp_r [DEPTH];
  logic [TMO_W-1:0]    mem_tmo_r   [DEPTH];
  logic [PW-1:0]       rd_ptr_r, wr_ptr_r, rd_next_s;
  logic [CW-1:0]       count_r, count_nx;
  logic [TMO_W-1:0]    timer_r;
  logic [3:0]          remain_r;
  logic [CMD_W-1:0]    cmd_r, cmd_nx;
  logic                send_cmd_r, done_r, busy_r, full_r, ovf_r, err_r;
  logic [2:0]          err_code_r, err_code_s;
  logic [7:0]          err_idx_r;
  logic [RESP_W-1:0]   bad_resp_r;
  logic [CMD_W-1:0]    head_data_s;
  logic [3:0]          head_nresp_s;
  logic [TMO_W-1:0]    head_tmo_s;
  logic                pop_s, cmd_load_s, timer_clr_s, timer_inc_s, remain_load_s, remain_dec_s;
  logic                err_set_s, done_set_s, start_clr_s, flush_s, push_ok_s, ovf_set_s;

  assign rd_next_s    = rd_ptr_r + PTR_ONE;
  assign head_data_s  = mem_data_r[rd_ptr_r];
  assign head_nresp_s = mem_nresp_r[rd_ptr_r];
  assign head_tmo_s   = mem_tmo_r[rd_ptr_r];

  assign send_cmd = send_cmd_r;
  assign cmd      = cmd_r;
  assign full     = full_r;
  assign count    = count_r;
  assign ovf      = ovf_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign err_code = err_code_r;
  assign err_idx  = err_idx_r;
  assign bad_resp = bad_resp_r;

  // Next-state and control strobes; abort overrides everything else.
  always_comb begin
    state_nx      = state_r;
    cmd_nx        = cmd_r;
    cmd_load_s    = 1'b0;
    pop_s         = 1'b0;
    timer_clr_s   = 1'b0;
    timer_inc_s   = 1'b0;
    remain_load_s = 1'b0;
    remain_dec_s  = 1'b0;
    err_set_s     = 1'b0;
    err_code_s    = 3'd0;
    done_set_s    = 1'b0;
    start_clr_s   = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (count_r != CNT_ZERO) begin
              state_nx    = SEND;
              start_clr_s = 1'b1;
              cmd_load_s  = 1'b1;
              cmd_nx      = head_data_s;
            end else begin
              done_set_s = 1'b1;
            end
          end else begin
            state_nx = IDLE;
          end
        end
        SEND: begin
          if (resp_rdy) begin
            state_nx = IDLE; err_set_s = 1'b1; err_code_s = 3'd4;
          end else begin
            state_nx    = WAIT_SENT;
            timer_clr_s = 1'b1;
          end
        end
        WAIT_SENT: begin
          if (resp_rdy) begin
            state_nx = IDLE; err_set_s = 1'b1; err_code_s = 3'd4;
          end else if (cmd_sent) begin
            state_nx      = WAIT_RESP;
            timer_clr_s   = 1'b1;
            remain_load_s = 1'b1;
          end else if (timer_r == SENT_LIM) begin
            state_nx = IDLE; err_set_s = 1'b1; err_code_s = 3'd1;
          end else begin
            timer_inc_s = 1'b1;
          end
        end
        WAIT_RESP: begin
          if (resp_rdy) begin
            if (remain_r > 4'd1) begin
              if (resp == ACK) begin
                remain_dec_s = 1'b1;
                timer_clr_s  = 1'b1;
              end else begin
                state_nx = IDLE; err_set_s = 1'b1; err_code_s = 3'd3;
              end
            end else if (resp == POS_ACK) begin
              pop_s = 1'b1;
              if ((count_r == CNT_ONE) && !load_cmd) begin
                state_nx   = IDLE;
                done_set_s = 1'b1;
              end else begin
                state_nx   = SEND;
                cmd_load_s = 1'b1;
                // With one entry left, the next head is the word being pushed now.
                cmd_nx     = (count_r == CNT_ONE) ? load_data : mem_data_r[rd_next_s];
              end
            end else begin
              state_nx = IDLE; err_set_s = 1'b1; err_code_s = 3'd3;
            end
          end else if ((head_tmo_s != TMO_ZERO) && (timer_r == head_tmo_s - TMO_ONE)) begin
            state_nx = IDLE; err_set_s = 1'b1; err_code_s = 3'd2;
          end else begin
            timer_inc_s = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Push acceptance, overflow detection and next occupancy.
  always_comb begin
    flush_s   = abort | err_set_s;
    push_ok_s = load_cmd & ~flush_s & (~full_r | pop_s);
    ovf_set_s = load_cmd & ~flush_s & full_r & ~pop_s;
    count_nx  = count_r;
    if (flush_s) begin
      count_nx = CNT_ZERO;
    end else if (push_ok_s && !pop_s) begin
      count_nx = count_r + CNT_ONE;
    end else if (!push_ok_s && pop_s) begin
      count_nx = count_r - CNT_ONE;
    end else begin
      count_nx = count_r;
    end
  end

  // State register, saturating wait timer and remaining-response counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      timer_r  <= TMO_ZERO;
      remain_r <= 4'd0;
    end else begin
      state_r <= state_nx;
      if (timer_clr_s) begin
        timer_r <= TMO_ZERO;
      end else if (timer_inc_s && (timer_r != TMO_MAX)) begin
        timer_r <= timer_r + TMO_ONE;
      end
      if (remain_load_s) begin
        remain_r <= (head_nresp_s == 4'd0) ? 4'd1 : head_nresp_s;
      end else if (remain_dec_s) begin
        remain_r <= remain_r - 4'd1;
      end
    end
  end

  // FIFO pointers and occupancy; a flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
    end else begin
      count_r <= count_nx;
      full_r  <= (count_nx == CNT_FULL);
      if (flush_s) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s)     rd_ptr_r <= rd_next_s;
      end
    end
  end

  // FIFO storage; contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_data_r[wr_ptr_r]  <= load_data;
      mem_nresp_r[wr_ptr_r] <= load_nresp;
      mem_tmo_r[wr_ptr_r]   <= load_tmo;
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r      <= {CMD_W{1'b0}};
      send_cmd_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      send_cmd_r <= cmd_load_s;
      done_r     <= done_set_s;
      busy_r     <= (state_nx != IDLE);
      if (cmd_load_s) cmd_r <= cmd_nx;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (start_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Sticky first-error report and completed-entry index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r      <= 1'b0;
      err_code_r <= 3'd0;
      err_idx_r  <= 8'd0;
      bad_resp_r <= {RESP_W{1'b0}};
    end else if (start_clr_s) begin
      err_r      <= 1'b0;
      err_code_r <= 3'd0;
      err_idx_r  <= 8'd0;
      bad_resp_r <= {RESP_W{1'b0}};
    end else begin
      if (pop_s) err_idx_r <= err_idx_r + 8'd1;
      if (err_set_s && !err_r) begin
        err_r      <= 1'b1;
        err_code_r <= err_code_s;
        if ((err_code_s == 3'd3) || (err_code_s == 3'd4)) bad_resp_r <= resp;
      end
    end
  end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Synthesizable command player/checker that sits between a command source (on-chip test controller or FPGA debug harness) and the RemoteComm transmit/receive path of the Knight's Tour robot. It holds a parametrised FIFO of 16-bit commands. Each entry carries an expected response count and a timeout, so one block sends commands, supervises `cmd_sent`, and checks every response byte: intermediate responses must be ACK (0x5A) and the final one POS_ACK (0xA5). It generalises the single-command send/ack/timeout flow to DEPTH queued commands with per-command multi-response checking, sticky error reporting and abort.

## Interface

- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CMD_W`, 16: command width.
- `RESP_W`, 8: response width.
- `TMO_W`, 24: timeout counter width.
- `SENT_TMO`, 60000: clocks allowed from `send_cmd` to `cmd_sent`.
- `POS_ACK`, 8'hA5: required final response.
- `ACK`, 8'h5A: required intermediate response.

Ports (one clock; reset is asynchronous and active-low):

- `clk`  in  1  system clock.
- `rst_n`  in  1  async active-low reset.
- `load_cmd`  in  1  push strobe.
- `load_data`  in  CMD_W  command to push.
- `load_nresp`  in  4  responses expected; 0 is treated as 1.
- `load_tmo`  in  TMO_W  per-response timeout in clocks; 0 disables the timeout.
- `start`  in  1  begin playing the queue.
- `abort`  in  1  stop and flush.
- `send_cmd`  out  1  one-cycle transmit strobe to RemoteComm.
- `cmd`  out  CMD_W  command being sent.
- `cmd_sent`  in  1  transmit-complete pulse.
- `resp_rdy`  in  1  response valid pulse.
- `resp`  in  RESP_W  response byte.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH+1)  entries queued.
- `ovf`  out  1  sticky: push was dropped because the FIFO was full.
- `busy`  out  1  not IDLE.
- `done`  out  1  one-cycle pulse: queue drained with no error.
- `err`  out  1  sticky error flag.
- `err_code`  out  3  1 = sent timeout, 2 = response timeout, 3 = wrong response, 4 = unexpected response.
- `err_idx`  out  8  entries fully completed before the error.
- `bad_resp`  out  RESP_W  offending byte (code 3 or 4).

## Operation

- FIFO entry = {data, nresp, tmo}.
  - A push while full is dropped and sets `ovf`.
  - A push is allowed in any state, including during playback.
  - Simultaneous push and pop is allowed when full.
- The entry is popped only when it completes, so the head is stable through SEND to WAIT_RESP.
- States: IDLE, SEND, WAIT_SENT, WAIT_RESP.
- IDLE:
  - `start` with `count`>0 goes to SEND; clears `err`, `err_code`, `err_idx`, `bad_resp` and `ovf`.
  - `start` with an empty FIFO pulses `done` next cycle and stays in IDLE.
  - `start` while busy is ignored.
- SEND:
  - Registers `cmd`, asserts `send_cmd` for exactly one cycle, clears the timer, goes to WAIT_SENT.
- WAIT_SENT:
  - `cmd_sent` goes to WAIT_RESP, clears the timer and loads the remaining-response counter with nresp.
  - Timer reaching SENT_TMO gives error 1.
- WAIT_RESP, on `resp_rdy`:
  - Remaining > 1 requires `ACK`; decrement and clear the timer.
  - Remaining = 1 requires `POS_ACK`; pop the entry and increment `err_idx`. If the FIFO is now empty go to IDLE and pulse `done`; otherwise go to SEND.
  - A wrong byte gives error 3 and is captured in `bad_resp`.
- WAIT_RESP timeout: tmo ≠ 0 and the timer reaching tmo gives error 2.
- `resp_rdy` in SEND or WAIT_SENT gives error 4. `resp_rdy` in IDLE is ignored.
- Any error:
  - Sets `err` and `err_code`, flushes the FIFO (`count`=0) and goes to IDLE.
  - Does not pulse `done`.
  - Only the first error is recorded.
- `abort`: flush and go to IDLE next cycle; no `done`, no error; overrides every other input.
- Timer: TMO_W bits, saturating, increments every cycle in WAIT_SENT and WAIT_RESP.

## Timing

- Reset values:
  - State IDLE; FIFO empty; `count`=0.
  - `full`, `ovf`, `busy`, `done`, `send_cmd`, `err` all 0.
  - `err_code`=0, `err_idx`=0, `cmd`=0, `bad_resp`=0.
- Reset mid-operation returns to these values immediately (async) and drops the queue.
- `start` at edge N gives `send_cmd`=1 in cycle N+1, with `cmd` valid the same cycle and held until the next SEND.
- A completed entry followed by another: `send_cmd` for the next entry 1 cycle after the final `resp_rdy`.
- `done` is asserted 1 cycle after the final POS_ACK, together with `busy` going to 0.
- Event and timeout in the same cycle: the event wins; no error.
- `count`/`full` update 1 cycle after a push or pop; `count`=DEPTH implies `full`.

## Test plan

- Push 3 entries (0x2000/nresp 1, 0x4001/nresp 1, 0x6021/nresp 2); model returns `cmd_sent` after 100 clocks and responses A5 / A5 / 5A,A5 -> three `send_cmd` pulses with matching `cmd`, then `done`, `err`=0, `err_idx`=3.
- `cmd_sent` withheld -> `err`=1, `err_code`=1 exactly SENT_TMO clocks after `send_cmd`; `count`=0.
- tmo=1000 and no response -> `err_code`=2 at 1000 clocks after `cmd_sent`; tmo=0 and no response for 10^5 clocks -> still busy, no error.
- Response 0x5A when nresp=1 -> `err_code`=3, `bad_resp`=0x5A, `err_idx`=0; `resp_rdy` during WAIT_SENT -> `err_code`=4.
- Push DEPTH+1 entries -> `full`=1, `ovf`=1, `count`=DEPTH; `abort` mid-WAIT_RESP -> IDLE next cycle, `count`=0, no `done`/`err`.
- Assert `rst_n`=0 mid-WAIT_SENT -> all outputs at reset values immediately; a fresh `start` after reset with an empty queue -> `done` only.
